// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU op codes, immediate
// formats, the control bundle and the immediate extraction helper.
// Optional feature macro: DECODE_RV32M_EN (adds mul/mulh/mulhsu/mulhu).
package decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] IN1_ZERO = 2'd0;
    localparam logic [1:0] IN1_RS1  = 2'd1;
    localparam logic [1:0] IN1_PC   = 2'd2;

`ifdef DECODE_RV32M_EN
    localparam int ALU_OP_W = 5;
`else
    localparam int ALU_OP_W = 4;
`endif

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = ALU_OP_W'(4'b0000),
        ALU_SUB  = ALU_OP_W'(4'b0001),
        ALU_XOR  = ALU_OP_W'(4'b0010),
        ALU_SLT  = ALU_OP_W'(4'b0011),
        ALU_SLTU = ALU_OP_W'(4'b0100),
        ALU_SLL  = ALU_OP_W'(4'b0101),
        ALU_SRL  = ALU_OP_W'(4'b0110),
        ALU_SRA  = ALU_OP_W'(4'b0111),
        ALU_OR   = ALU_OP_W'(4'b1000),
`ifdef DECODE_RV32M_EN
        ALU_AND    = ALU_OP_W'(4'b1001),
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011
`else
        ALU_AND  = ALU_OP_W'(4'b1001)
`endif
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
    } imm_sel_t;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_in1_src;
        logic       alu_in2_src;
        alu_op_t    alu_op;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic       illegal;
    } ctrl_t;

    // 32-bit sign-extended immediate for the selected format; NONE yields 0
    function automatic logic [31:0] imm32(input logic [31:0] i, input imm_sel_t sel);
        case (sel)
            IMM_I:   imm32 = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm32 = {i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_core.sv
// Combinational RV32I decoder: instruction word -> control bundle, immediate
// and register indices. Illegal encodings clear all side-effect controls.
// Optional feature macro: DECODE_RV32M_EN.
module decode_core
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    imm_sel_t   sel;
    ctrl_t      c;
    logic       ill;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];
    assign rd  = instr[11:7];
    assign imm = XLEN'($signed(imm32(instr, sel)));

    // opcode/funct decode into the control bundle, then mask on illegal
    always_comb begin
        c   = '0;
        sel = IMM_NONE;
        ill = 1'b0;
        c.alu_in1_src = IN1_RS1;
        c.alu_op      = ALU_ADD;
        case (opc)
            OP_LUI:   begin sel = IMM_U; c.reg_write = 1'b1; c.alu_in1_src = IN1_ZERO; end
            OP_AUIPC: begin sel = IMM_U; c.reg_write = 1'b1; c.alu_in1_src = IN1_PC; end
            OP_JAL:   begin sel = IMM_J; c.reg_write = 1'b1; c.alu_in1_src = IN1_PC; c.jump = 1'b1; end
            OP_JALR: begin
                sel = IMM_I; c.reg_write = 1'b1; c.jump = 1'b1; c.jump_reg = 1'b1;
                ill = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                sel = IMM_B; c.branch = 1'b1; c.alu_in2_src = 1'b1; c.alu_op = ALU_SUB;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                sel = IMM_I; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                sel = IMM_S; c.mem_write = 1'b1;
                ill = (f3 > 3'b010);
            end
            OP_IMM: begin
                sel = IMM_I; c.reg_write = 1'b1;
                case (f3)
                    3'b000: c.alu_op = ALU_ADD;
                    3'b010: c.alu_op = ALU_SLT;
                    3'b011: c.alu_op = ALU_SLTU;
                    3'b100: c.alu_op = ALU_XOR;
                    3'b110: c.alu_op = ALU_OR;
                    3'b111: c.alu_op = ALU_AND;
                    3'b001: begin c.alu_op = ALU_SLL; ill = (f7 != F7_BASE); end
                    default: begin
                        c.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        ill = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                endcase
            end
            OP_REG: begin
                c.reg_write = 1'b1; c.alu_in2_src = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  c.alu_op = ALU_ADD;
                        3'b001:  c.alu_op = ALU_SLL;
                        3'b010:  c.alu_op = ALU_SLT;
                        3'b011:  c.alu_op = ALU_SLTU;
                        3'b100:  c.alu_op = ALU_XOR;
                        3'b101:  c.alu_op = ALU_SRL;
                        3'b110:  c.alu_op = ALU_OR;
                        default: c.alu_op = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000)      c.alu_op = ALU_SUB;
                    else if (f3 == 3'b101) c.alu_op = ALU_SRA;
                    else                   ill = 1'b1;
`ifdef DECODE_RV32M_EN
                end else if (f7 == F7_MULDIV) begin
                    case (f3)
                        3'b000:  c.alu_op = ALU_MUL;
                        3'b001:  c.alu_op = ALU_MULH;
                        3'b010:  c.alu_op = ALU_MULHSU;
                        3'b011:  c.alu_op = ALU_MULHU;
                        default: ill = 1'b1;  // div/divu/rem/remu decode as illegal
                    endcase
`endif
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            c.reg_write = 1'b0;
            c.mem_write = 1'b0;
            c.branch    = 1'b0;
            c.jump      = 1'b0;
            c.jump_reg  = 1'b0;
        end
        c.illegal = ill;
        ctrl = c;
    end
endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes the fetch word and buffers decoded
// bundles in a DEPTH-entry FIFO with valid/ready on both sides and flush.
// Optional feature macro: DECODE_RV32M_EN (via decode_pkg / decode_core).
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output ctrl_t           out_ctrl
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        ctrl_t           ctrl;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             dec;
    logic [PTR_W-1:0]   wptr, rptr;
    logic [CNT_W-1:0]   count;
    logic               push, pop;

    decode_core #(.XLEN(XLEN)) u_core (
        .instr (in_instr),
        .ctrl  (dec.ctrl),
        .imm   (dec.imm),
        .rs1   (dec.rs1),
        .rs2   (dec.rs2),
        .rd    (dec.rd)
    );
    assign dec.pc = in_pc;

    // full/empty come straight from the registered count (no pop look-through)
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_pc   = mem[rptr].pc;
    assign out_imm  = mem[rptr].imm;
    assign out_rs1  = mem[rptr].rs1;
    assign out_rs2  = mem[rptr].rs2;
    assign out_rd   = mem[rptr].rd;
    assign out_ctrl = mem[rptr].ctrl;

    // FIFO storage, pointers (power-of-two depth wraps naturally) and count
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= dec;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (DEPTH=2, XLEN=32).
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    ctrl_t       out_ctrl;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] I_ADDI = 32'h00500093; // addi x1,x0,5
    localparam logic [31:0] I_SW   = 32'h0020A423; // sw x2,8(x1)
    localparam logic [31:0] I_BEQ  = 32'h00208863; // beq x1,x2,16
    localparam logic [31:0] I_LW   = 32'hFFC0A183; // lw x3,-4(x1)
    localparam logic [31:0] I_LUI  = 32'h123453B7; // lui x7,0x12345
    localparam logic [31:0] I_SRAI = 32'h40A4D293; // srai x5,x9,10
    localparam logic [31:0] I_MUL  = 32'h02208033; // mul x0,x1,x2

    decode_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        step();
        reset = 1'b0;

        // single addi, one-cycle latency, then drains
        out_ready = 1'b1;
        drive(1'b1, I_ADDI, 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("addi_valid", out_valid, 1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_imm", out_imm, 5);
        chk("addi_rd", out_rd, 1);
        chk("addi_op", out_ctrl.alu_op, ALU_ADD);
        chk("addi_rw", out_ctrl.reg_write, 1);
        chk("addi_ill", out_ctrl.illegal, 0);
        step();
        chk("addi_drain", out_valid, 0);

        // fill with sw, beq; lw is held off while full
        out_ready = 1'b0;
        drive(1'b1, I_SW, 32'h200);
        step();
        drive(1'b1, I_BEQ, 32'h204);
        step();
        chk("full_in_ready", in_ready, 0);
        drive(1'b1, I_LW, 32'h208);
        step();
        chk("full_hold_ready", in_ready, 0);
        chk("sw_pc", out_pc, 32'h200);
        chk("sw_mw", out_ctrl.mem_write, 1);
        chk("sw_rw", out_ctrl.reg_write, 0);
        chk("sw_imm", out_imm, 8);
        chk("sw_rs2", out_rs2, 2);
        out_ready = 1'b1;  // pop sw; full, so lw still refused this edge
        step();
        chk("beq_pc", out_pc, 32'h204);
        chk("beq_op", out_ctrl.alu_op, ALU_SUB);
        chk("beq_in2", out_ctrl.alu_in2_src, 1);
        chk("beq_br", out_ctrl.branch, 1);
        chk("beq_imm", out_imm, 16);
        chk("beq_in_ready", in_ready, 1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("lw_pc", out_pc, 32'h208);
        chk("lw_imm", out_imm, 32'hFFFF_FFFC);
        chk("lw_rd", out_rd, 3);
        chk("lw_m2r", out_ctrl.mem_to_reg, 1);
        step();
        chk("lw_drain", out_valid, 0);

        // steady push+pop at count=1 across pointer wraps
        out_ready = 1'b0;
        drive(1'b1, I_LUI, 32'h300);
        step();
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_in1", out_ctrl.alu_in1_src, IN1_ZERO);
        chk("lui_rd", out_rd, 7);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, I_ADDI, 32'h304 + 32'(4 * i));
            step();
            chk("stream_pc", out_pc, 32'h304 + 32'(4 * i));
            chk("stream_cnt1", {out_valid, in_ready}, 2'b11);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("stream_drain", out_valid, 0);

        // srai and an illegal all-zero word
        out_ready = 1'b0;
        drive(1'b1, I_SRAI, 32'h400);
        step();
        chk("srai_op", out_ctrl.alu_op, ALU_SRA);
        chk("srai_sh", out_imm[4:0], 10);
        chk("srai_rs1", out_rs1, 9);
        chk("srai_ill", out_ctrl.illegal, 0);
        drive(1'b1, 32'h0000_0000, 32'h404);
        step();
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("zero_pc", out_pc, 32'h404);
        chk("zero_ill", out_ctrl.illegal, 1);
        chk("zero_rw", out_ctrl.reg_write, 0);

        // flush with count=2 while input is offered
        drive(1'b1, I_ADDI, 32'h500);
        step();
        chk("pre_flush_full", in_ready, 0);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, I_LUI, 32'h504);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        step();
        chk("flush_dropped", out_valid, 0);

        // reset mid-stream with count=2
        out_ready = 1'b0;
        drive(1'b1, I_ADDI, 32'h600);
        step();
        drive(1'b1, I_SW, 32'h604);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("pre_rst_full", in_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_ready", in_ready, 1);
        chk("mrst_pc", out_pc, 0);

        // mul: decoded with RV32M, illegal otherwise
        drive(1'b1, I_MUL, 32'h700);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("mul_valid", out_valid, 1);
`ifdef DECODE_RV32M_EN
        chk("mul_op", out_ctrl.alu_op, ALU_MUL);
        chk("mul_ill", out_ctrl.illegal, 0);
`else
        chk("mul_ill", out_ctrl.illegal, 1);
        chk("mul_rw", out_ctrl.reg_write, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
